id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. Captures decoded control, register numbers and operands from ID and presents them to EX. Its `ex_rs`/`ex_rt`/`ex_dst`/`ex_reg_write` outputs drive the forwarding unit's source/destination compare inputs. It raises a stall toward PC/IF-ID when an EX-stage load feeds the instruction in ID, and inserts a bubble. It also counts stall and flush events.

## Interface
- `DATA_W`, 32, operand/immediate/PC width
- `CNT_W`, 16, width of saturating event counters
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd` in 5 each: decoded register numbers
- `id_reg_dst` in 1: 1 = destination is rd, 0 = destination is rt
- `id_uses_rt` in 1: instruction reads rt as a source
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src` in 1 each: control bits
- `id_alu_op` in 4: ALU operation
- `id_rs_data`, `id_rt_data`, `id_imm`, `id_pc4` in DATA_W each: operands, sign-extended immediate, PC+4
- `flush` in 1: branch/jump resolved taken in EX; squash ID
- `hold` in 1: global freeze (multi-cycle EX / memory wait)
- `ex_valid` out 1, `ex_rs`, `ex_rt`, `ex_dst` out 5, `ex_*` control and data outs mirroring the `id_*` fields
- `stall` out 1: freeze PC and IF/ID this cycle
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters

## Operation
- `ex_dst` = `id_reg_dst ? id_rd : id_rt`, resolved at capture.
- Load-use hazard `lu`: `ex_valid & ex_mem_read & ex_dst!=0 & id_valid & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt))`.
- `stall` = `lu & ~flush & ~hold`. It is combinational from the current EX register and the ID inputs.
- Register update at each posedge, in priority order:
  1. `rst`: all outputs 0, including both counters.
  2. `hold`: every EX register keeps its value. Counters are unchanged.
  3. `flush`: load a bubble, then `flush_cnt`+1.
  4. `stall`: load a bubble, then `stall_cnt`+1.
  5. Otherwise: capture all `id_*` fields. `ex_valid` = `id_valid`.
- Bubble:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` = 0.
  - `ex_dst`, `ex_rs`, `ex_rt` = 0, so the bubble never matches in the forwarding compare.
  - Data fields are don't-care and are driven 0.
- When `id_valid`=0, capture forces `ex_reg_write`/`ex_mem_read`/`ex_mem_write` to 0, whatever the `id_*` values are.
- Counters saturate at all-ones; no wrap.
- `flush` together with `lu`: only the flush counter increments and `stall`=0. The squashed instruction is not held.

## Timing
- Latency 1 cycle, ID inputs to EX outputs.
- `stall` is asserted in the same cycle the hazard is present. It lasts exactly 1 cycle per load-use pair, because the next cycle EX holds the bubble and `lu` is therefore 0.
- Reset is synchronous. It applies on the first edge with `rst`=1 and overrides `hold`/`flush`. Mid-stall reset clears EX; `stall` drops combinationally once `ex_valid`=0.

## Configuration
- `ID_EX_LOAD_USE_EN`
  - Defined: load-use detection as above.
  - Undefined: `lu` is tied 0 and `stall` is constant 0. `stall_cnt` stays 0. The pipeline relies on compiler-inserted NOPs. Flush, hold and forwarding-facing outputs are unchanged.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random `id_*` → all `ex_*` = 0, `stall`=0, both counters 0.
- Plain pass-through: `add $3,$1,$2` (`id_rs`=1, `id_rt`=2, `id_rd`=3, `id_reg_dst`=1, `id_reg_write`=1) → next cycle `ex_dst`=3, `ex_reg_write`=1, `ex_valid`=1, `stall`=0.
- Load-use: EX holds `lw $5` (`ex_mem_read`=1, `ex_dst`=5) and ID holds `add $6,$5,$7` → `stall`=1 that cycle. The next EX is a bubble (`ex_valid`=0, `ex_dst`=0), `stall_cnt`=1, and ID's `add` is captured one cycle later. With the macro undefined: `stall`=0 and `add` is captured directly.
- $zero / rt-unused: EX `lw $0`, ID uses `$0` → no stall. EX `lw $4`, ID `addi $4,$9,1` with `id_uses_rt`=0 and `id_rt`=4 → no stall.
- Flush vs stall: load-use present with `flush`=1 the same cycle → `stall`=0, bubble loaded, `flush_cnt`+1, `stall_cnt` unchanged.
- Hold and saturation: `hold`=1 for 3 cycles with changing `id_*` → `ex_*` frozen. Preload `stall_cnt`=0xFFFF via repeated hazards → an additional hazard leaves it at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures decoded control, register numbers and operands from ID, detects
// load-use hazards against the instruction currently in EX, inserts bubbles
// on flush/stall and counts both kinds of event with saturating counters.
// Optional feature macro: ID_EX_LOAD_USE_EN enables load-use detection;
// when undefined, stall is constant 0 and software supplies the NOPs.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_dst,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic       lu;
    logic [4:0] id_dst;
    logic       bubble;

    // Destination register is resolved in ID so the forwarding unit sees one field.
    assign id_dst = id_reg_dst ? id_rd : id_rt;

`ifdef ID_EX_LOAD_USE_EN
    // Load in EX whose destination is a source of the instruction in ID.
    always_comb begin
        lu = ex_valid & ex_mem_read & (ex_dst != 5'd0) & id_valid &
             ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
    end
`else
    logic unused_uses_rt;
    assign unused_uses_rt = id_uses_rt;

    // Detection disabled: the compiler is trusted to separate loads from uses.
    always_comb begin
        lu = 1'b0;
    end
`endif

    // A taken flush or a global hold always overrides the load-use stall.
    assign stall  = lu & ~flush & ~hold;
    assign bubble = flush | stall;

    // EX register: reset, hold, bubble or capture, in that priority.
    always_ff @(posedge clk) begin
        if (rst || (!hold && bubble)) begin
            ex_valid      <= 1'b0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_dst        <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= 4'd0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_pc4        <= '0;
        end else if (!hold) begin
            ex_valid      <= id_valid;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dst        <= id_dst;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_src    <= id_alu_src;
            ex_alu_op     <= id_alu_op;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_pc4        <= id_pc4;
        end
    end

    // Event counters: index 0 counts stalls, index 1 counts flushes.
    logic [1:0]       evt;
    logic [CNT_W-1:0] cnt_reg  [2];
    logic [CNT_W-1:0] cnt_next [2];

    assign evt[0] = stall;
    assign evt[1] = flush & ~hold;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            // Saturating increment: stick at all-ones instead of wrapping.
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (evt[gi] && !(&cnt_reg[gi])) begin
                    cnt_next[gi] = cnt_reg[gi] + 1'b1;
                end
            end

            // Counter register with synchronous clear.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule
